// File: rtl/axi_lite_block_reader.sv
// AXI4-Lite read master: fetches BEATS consecutive words into o_block_data, one read outstanding at a time.
// Optional watchdog is compiled in when AXI_RD_TIMEOUT_EN is defined.
module axi_lite_block_reader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BEATS          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH-1:0]       i_base_addr,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic [BEATS*DATA_WIDTH-1:0] o_block_data,
    output logic                        o_arvalid,
    output logic [ADDR_WIDTH-1:0]       o_araddr,
    output logic [2:0]                  o_arprot,
    input  logic                        i_arready,
    input  logic                        i_rvalid,
    input  logic [DATA_WIDTH-1:0]       i_rdata,
    input  logic [1:0]                  i_rresp,
    output logic                        o_rready,
    output logic                        o_count_run,
    output logic                        o_count_restartn,
    input  logic                        i_count_done,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR      = 2'd1,
        S_DATA      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    localparam int                    IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BEATS - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [BEATS*DATA_WIDTH-1:0] data_q, data_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic                        run_q, run_d;
    logic                        restartn_q, restartn_d;
    logic                        timeout;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // arvalid/araddr stay stable until accepted, and rready is only high while one read is pending.
    assign o_busy           = (state_q != S_IDLE);
    assign o_arvalid        = (state_q == S_ADDR);
    assign o_rready         = (state_q == S_DATA);
    assign o_araddr         = addr_q;
    assign o_arprot         = 3'b000;
    assign o_done           = done_q;
    assign o_error          = err_q;
    assign o_block_data     = data_q;
    assign o_count_run      = run_q;
    assign o_count_restartn = restartn_q;
    assign o_dbg_state      = state_q;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            stalled;

    assign stalled = ((state_q == S_ADDR) && !i_arready) || ((state_q == S_DATA) && !i_rvalid);
    assign timeout = stalled && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if (stalled && !timeout) wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        done_d     = 1'b0;
        run_d      = 1'b0;
        restartn_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    idx_d      = '0;
                    addr_d     = i_base_addr;
                    err_d      = 1'b0;
                    restartn_d = 1'b0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (i_rvalid) begin
                    data_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = i_rdata;
                    run_d = 1'b1;
                    if (i_rresp != 2'b00) err_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_WAIT_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = addr_q + STRIDE;
                        state_d = S_ADDR;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (i_count_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A counter done outside WAIT_DONE means the counter and reader disagree on beat count.
        if (i_count_done && (state_q != S_WAIT_DONE)) err_d = 1'b1;
        if (timeout) begin
            err_d      = 1'b1;
            restartn_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
            restartn_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            done_q     <= done_d;
            run_q      <= run_d;
            restartn_q <= restartn_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_block_reader.sv
// Bench for axi_lite_block_reader: randomized AXI slave and burst-counter peer, block-level reference model.
module tb_axi_lite_block_reader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEATS = 16;
    localparam int BW    = BEATS * DW;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic          o_busy, o_done, o_error, o_arvalid, o_rready;
    logic [BW-1:0] o_block_data;
    logic [AW-1:0] o_araddr;
    logic [2:0]    o_arprot;
    logic          i_arready = 1'b0;
    logic          i_rvalid = 1'b0;
    logic [DW-1:0] i_rdata = '0;
    logic [1:0]    i_rresp = '0;
    logic          o_count_run, o_count_restartn;
    logic          i_count_done;
    logic [1:0]    o_dbg_state;

    logic cdone = 1'b0;
    logic inj_done = 1'b0;
    assign i_count_done = cdone | inj_done;

    always #5 clk = ~clk;

    axi_lite_block_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .arstn(arstn), .i_start(i_start), .i_base_addr(i_base_addr),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_block_data(o_block_data),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arprot(o_arprot), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_rready(o_rready),
        .o_count_run(o_count_run), .o_count_restartn(o_count_restartn),
        .i_count_done(i_count_done), .o_dbg_state(o_dbg_state)
    );

    // Scoreboard and block-level model
    int            n_checks = 0;
    int            n_errors = 0;
    bit            chk_en = 1'b0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] ar_log[$];
    logic [BW-1:0] exp_blk = '0;
    logic          exp_err = 1'b0;
    bit            exp_timeout = 1'b0;
    int            blk_beats = 0, blk_runs = 0, blk_restarts = 0, blk_rready = 0, done_cnt = 0;

    // Slave configuration
    logic [DW-1:0] cfg_salt = '0;
    int            cfg_err_beat = -1;
    int            cfg_max_stall = 0;
    bit            cfg_never_r = 1'b0;

    // Values sampled at the falling edge for the peer models
    bit            s_ar_fire = 1'b0, s_r_fire = 1'b0, s_run = 1'b0, s_restartn = 1'b1;
    logic [AW-1:0] s_araddr = '0;
    bit            prev_r_fire = 1'b0, prev_ar_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    function automatic void chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("run_follows_r", BW'(o_count_run), BW'(prev_r_fire));
            chk("one_outstanding", BW'(o_arvalid & o_rready), '0);
            chk("arprot", BW'(o_arprot), '0);
            if (prev_ar_stall) begin
                chk("ar_hold_valid", BW'(o_arvalid), BW'(1));
                chk("ar_hold_addr", BW'(o_araddr), BW'(prev_addr));
            end
            if (o_arvalid && i_arready) begin
                ar_log.push_back(o_araddr);
                if (exp_q.size() > 0) chk("araddr", BW'(o_araddr), BW'(exp_q.pop_front()));
                else                  chk("ar_count", BW'(ar_log.size()), BW'(BEATS));
            end
            if (o_rready && i_rvalid) blk_beats++;
            if (o_rready) blk_rready++;
            if (o_count_run) blk_runs++;
            if (!o_count_restartn) blk_restarts++;
            if (o_done) begin
                done_cnt++;
                chk("done_busy", BW'(o_busy), '0);
                chk("done_error", BW'(o_error), BW'(exp_err));
                if (exp_timeout) begin
                    chk("timeout_rready_cycles", BW'(blk_rready), BW'(8));
                end else begin
                    chk("block_data", o_block_data, exp_blk);
                    chk("beats", BW'(blk_beats), BW'(BEATS));
                    chk("run_pulses", BW'(blk_runs), BW'(BEATS));
                    chk("restart_pulses", BW'(blk_restarts), BW'(1));
                    chk("ar_left", BW'(exp_q.size()), '0);
                end
            end
        end
        s_ar_fire     = o_arvalid && i_arready;
        s_r_fire      = o_rready && i_rvalid;
        s_run         = o_count_run;
        s_restartn    = o_count_restartn;
        s_araddr      = o_araddr;
        prev_r_fire   = s_r_fire;
        prev_ar_stall = o_arvalid && !i_arready;
        prev_addr     = o_araddr;
    end

    // Peer models: AXI slave with random stalls and a burst counter (LIMIT=BEATS-1)
    int            cnt = 0, r_wait = 0, ar_wait = 0;
    bit            pending = 1'b0;
    logic [AW-1:0] paddr = '0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!arstn) begin
                cnt = 0; cdone = 1'b0; pending = 1'b0; r_wait = 0; ar_wait = 0;
                i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = 2'b00;
            end else begin
                cdone = 1'b0;
                if (!s_restartn) cnt = 0;
                else if (s_run) begin
                    if (cnt == BEATS - 1) begin cnt = 0; cdone = 1'b1; end
                    else cnt++;
                end
                if (s_ar_fire) begin
                    pending = 1'b1; paddr = s_araddr; r_wait = $urandom_range(0, cfg_max_stall);
                end
                if (s_r_fire) begin
                    pending = 1'b0; ar_wait = $urandom_range(0, cfg_max_stall);
                end
                if (pending) begin
                    i_arready = 1'b0;
                    if (r_wait > 0) begin
                        r_wait--; i_rvalid = 1'b0; i_rdata = $urandom();
                    end else begin
                        i_rvalid = !cfg_never_r;
                        i_rdata  = paddr ^ cfg_salt;
                        i_rresp  = (blk_beats == cfg_err_beat) ? 2'b10 : 2'b00;
                    end
                end else begin
                    i_rvalid = 1'b0; i_rresp = 2'b00;
                    if (ar_wait > 0) begin ar_wait--; i_arready = 1'b0; end
                    else i_arready = 1'b1;
                end
            end
        end
    end

    task automatic begin_block(input logic [AW-1:0] base, input logic [DW-1:0] salt,
                               input int err_beat, input int max_stall);
        int budget;
        budget = 0;
        while (o_busy && budget < 4000) begin @(posedge clk); #1; budget++; end
        exp_q.delete(); ar_log.delete();
        for (int k = 0; k < BEATS; k++) begin
            exp_q.push_back(base + AW'(4 * k));
            exp_blk[k*DW +: DW] = (base + AW'(4 * k)) ^ salt;
        end
        exp_err = (err_beat >= 0) && (err_beat < BEATS);
        exp_timeout = 1'b0;
        cfg_salt = salt; cfg_err_beat = err_beat; cfg_max_stall = max_stall;
        blk_beats = 0; blk_runs = 0; blk_restarts = 0; blk_rready = 0;
        i_base_addr = base;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_base_addr = $urandom();
        @(negedge clk);
        chk("start_busy", BW'(o_busy), BW'(1));
        chk("start_error_clear", BW'(o_error), '0);
    endtask

    task automatic wait_done(input bit hold_start, input bit inj_cd);
        int budget, d0;
        bit injected;
        d0 = done_cnt; budget = 0; injected = 1'b0;
        while (done_cnt == d0 && budget < 4000) begin
            @(posedge clk); #1; budget++;
            if (hold_start) i_start = (blk_runs < BEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
            inj_done = 1'b0;
            if (inj_cd && !injected && o_rready && blk_beats == 3) begin
                inj_done = 1'b1; injected = 1'b1;
            end
        end
        i_start = 1'b0; inj_done = 1'b0;
        chk("done_count", BW'(done_cnt - d0), BW'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, BW'(o_busy), '0);
        chk({tag, "_done"}, BW'(o_done), '0);
        chk({tag, "_error"}, BW'(o_error), '0);
        chk({tag, "_arvalid"}, BW'(o_arvalid), '0);
        chk({tag, "_rready"}, BW'(o_rready), '0);
        chk({tag, "_run"}, BW'(o_count_run), '0);
        chk({tag, "_restartn"}, BW'(o_count_restartn), BW'(1));
        chk({tag, "_block_data"}, o_block_data, '0);
    endtask

    initial begin
        int budget, eb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        arstn = 1'b1;
        chk_en = 1'b1;

        // Zero-wait block, rdata = address
        begin_block(32'h0000_1000, '0, -1, 0);
        wait_done(1'b0, 1'b0);
        chk("pin_word0", BW'(o_block_data[31:0]), BW'(32'h0000_1000));
        chk("pin_word15", BW'(o_block_data[15*32 +: 32]), BW'(32'h0000_103C));
        if (ar_log.size() == BEATS) begin
            chk("pin_ar0", BW'(ar_log[0]), BW'(32'h0000_1000));
            chk("pin_ar15", BW'(ar_log[15]), BW'(32'h0000_103C));
        end else chk("pin_ar_log_size", BW'(ar_log.size()), BW'(BEATS));

        // Same block with random stalls
        begin_block(32'h0000_1000, '0, -1, 5);
        wait_done(1'b0, 1'b0);
        chk("pin_word7", BW'(o_block_data[7*32 +: 32]), BW'(32'h0000_101C));

        // Error response on beat 7
        begin_block(32'h0000_1000, '0, 7, 5);
        wait_done(1'b0, 1'b0);
        chk("pin_error_after_done", BW'(o_error), BW'(1));

        // Start held/pulsed while busy, then a start one cycle after done
        begin_block(32'h0000_2000, $urandom(), -1, 3);
        wait_done(1'b1, 1'b0);
        begin_block(32'h0000_3000, $urandom(), -1, 0);
        wait_done(1'b0, 1'b0);

        // Address wrap
        begin_block(32'hFFFF_FFF0, '0, -1, 2);
        wait_done(1'b0, 1'b0);
        if (ar_log.size() == BEATS) begin
            chk("pin_wrap_ar3", BW'(ar_log[3]), BW'(32'hFFFF_FFFC));
            chk("pin_wrap_ar4", BW'(ar_log[4]), '0);
        end else chk("pin_wrap_log_size", BW'(ar_log.size()), BW'(BEATS));

        // Counter done arriving mid-transfer
        begin_block(32'h0000_4000, $urandom(), -1, 0);
        exp_err = 1'b1;
        wait_done(1'b0, 1'b1);

        // Random blocks
        for (int b = 0; b < 6; b++) begin
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            begin_block($urandom(), $urandom(), eb, $urandom_range(0, 5));
            wait_done(1'b0, 1'b0);
        end

        // Reset while waiting for beat 5 data
        begin_block(32'h0000_5000, $urandom(), -1, 0);
        budget = 0;
        while (!(o_rready && blk_beats == 5) && budget < 500) begin
            @(posedge clk); #1; budget++;
        end
        chk("reset_at_beat5", BW'(blk_beats), BW'(5));
        arstn = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        chk_en = 1'b1;

        // Recovery after reset
        begin_block(32'h0000_7000, $urandom(), -1, 4);
        wait_done(1'b0, 1'b0);

`ifdef AXI_RD_TIMEOUT_EN
        // Slave never returns data: watchdog ends the block
        cfg_never_r = 1'b1;
        begin_block(32'h0000_6000, '0, -1, 0);
        exp_timeout = 1'b1;
        exp_err = 1'b1;
        wait_done(1'b0, 1'b0);
        chk("timeout_idle", BW'(o_busy), '0);
        cfg_never_r = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/axi_lite_block_reader.md
Name: axi_lite_block_reader

Overview:
- AXI4-Lite read master that fetches one block of BEATS consecutive words from memory into a flat output buffer.
- Issues one single-beat read per word (AR then R).
- Sits directly upstream of the burst counter: drives its run/restartn inputs and consumes its done pulse as end-of-block confirmation.
- Used by the cache refill path.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; word stride = DATA_WIDTH/8 bytes.
- BEATS, 16, words per block; the paired burst counter is built with LIMIT = BEATS-1, SIZE = BEATS.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with AXI_RD_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- i_start  in  1  request a block read; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  block base address; captured on accepted start.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the block is complete.
- o_error  out  1  sticky error; cleared on next accepted start.
- o_block_data  out  BEATS*DATA_WIDTH  word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_arvalid  out  1  AR valid.
- o_araddr  out  ADDR_WIDTH  AR address.
- o_arprot  out  3  constant 3'b000.
- i_arready  in  1  AR ready.
- i_rvalid  in  1  R valid.
- i_rdata  in  DATA_WIDTH  R data.
- i_rresp  in  2  R response.
- o_rready  out  1  R ready.
- o_count_run  out  1  to counter run; one pulse per accepted beat.
- o_count_restartn  out  1  to counter restartn; active-low synchronous clear.
- i_count_done  in  1  from counter done.

Behaviour:
- Reset: state IDLE, beat index 0.
  - o_busy, o_done, o_error, o_arvalid, o_rready, o_count_run = 0.
  - o_count_restartn = 1; o_block_data = 0.
- FSM states: IDLE, ADDR, DATA, WAIT_DONE. All outputs registered or decoded from state only.
- IDLE:
  - On i_start: capture i_base_addr, index = 0, clear o_error.
  - Drive o_count_restartn = 0 for exactly that one cycle, then -> ADDR.
- ADDR:
  - o_arvalid = 1; o_araddr = base + index*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
  - Address and valid stay stable until i_arready.
  - On arvalid & arready -> DATA, same cycle.
- DATA:
  - o_rready = 1.
  - On i_rvalid: write i_rdata into word[index]; o_count_run = 1 next cycle, exactly one cycle.
  - If index == BEATS-1 -> WAIT_DONE; else index+1 -> ADDR.
  - No AR is issued while waiting for R: at most one outstanding read.
- WAIT_DONE:
  - On i_count_done -> IDLE with o_done = 1 for one cycle.
  - Counter done arrives 1-2 cycles after the final run pulse.
- Error handling:
  - i_rresp != 2'b00 on any beat sets o_error; data is still stored and the transfer continues.
  - i_count_done seen in any state other than WAIT_DONE sets o_error (counter/reader beat mismatch) and is otherwise ignored.
- i_start while busy is ignored, with no queueing.
- o_block_data holds its value after done until overwritten beat by beat in the next transfer.
- Reset asserted mid-transfer: immediate return to reset values. Any outstanding AXI read is abandoned; the system resets the slave too.
- o_done and o_error are valid together: on the o_done cycle, o_error reflects the whole block.

Optional Feature:
- AXI_RD_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles in ADDR without arready, or in DATA without rvalid.
  - When the count reaches TIMEOUT_CYCLES: set o_error, drop arvalid/rready, pulse o_count_restartn low one cycle, go to IDLE with an o_done pulse.
  - The watchdog clears on every handshake.
- AXI_RD_TIMEOUT_EN undefined: no watchdog logic; the reader waits indefinitely.

Test Plan:
- Bench setup: instantiate the burst counter (LIMIT=15, SIZE=16) wired to the count ports.
- Base 0x1000, slave with zero-wait AR and R, rdata = addr -> 16 ARs at 0x1000..0x103C, word k = 0x1000+4k, 16 run pulses, one o_done, o_error = 0.
- Random arready/rvalid stalls of 0-5 cycles -> araddr and arvalid held stable while stalled; same data as the zero-wait case; exactly one done pulse.
- Beat 7 returns rresp = 2'b10 -> all 16 beats still fetched; o_error = 1 at o_done; cleared on next i_start.
- i_start pulsed repeatedly while busy -> ignored; a start one cycle after o_done begins a new block and restartn pulses low once.
- Base 0xFFFF_FFF0 -> addresses wrap to 0x0000_0000 after 0xFFFF_FFFC.
- Reset mid-DATA at beat 5 -> all outputs return to reset values next cycle.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never asserts rvalid -> o_error = 1 and o_done pulse after 8 stalled cycles, FSM in IDLE.
